// File: rtl/dsm_pkg.sv
// Shared constants and state type for the DSM read/verify sequencer.
// Imported by dsm_read_ctrl and dsm_avg_acc.
package dsm_pkg;

    localparam int CNT_W       = 9;
    localparam int WIN_W       = 9;
    localparam int AVG_LOG_MAX = 3;
    localparam int SETTLE_CYC  = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONV,
        CAPT,
        ACC,
        DONE
    } rd_state_e;

endpackage

// File: rtl/dsm_avg_acc.sv
// Conversion accumulator: sums captured DSM counts, tracks saturation,
// then shifts down to the average and compares it against the verify level.
module dsm_avg_acc #(
    parameter int CNT_W       = dsm_pkg::CNT_W,
    parameter int WIN_W       = dsm_pkg::WIN_W,
    parameter int AVG_LOG_MAX = dsm_pkg::AVG_LOG_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [1:0]       avg_log,
    input  logic [CNT_W-1:0] lvl,
    input  logic             add,
    input  logic [CNT_W-1:0] sample,
    input  logic [WIN_W-1:0] win,
    input  logic             result,
    output logic [1:0]       n_log,
    output logic [CNT_W-1:0] res_count,
    output logic             res_pass,
    output logic             res_sat
);
    import dsm_pkg::*;

    localparam int ACC_W = CNT_W + AVG_LOG_MAX;

    logic [ACC_W-1:0] acc;
    logic             sat;
    logic [1:0]       log_q;
    logic [CNT_W-1:0] lvl_q;
    logic [1:0]       log_c;
    logic [CNT_W-1:0] avg;

    assign log_c = (avg_log > 2'(AVG_LOG_MAX)) ? 2'(AVG_LOG_MAX) : avg_log;
    assign avg   = CNT_W'(acc >> log_q);
    assign n_log = log_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            sat       <= 1'b0;
            log_q     <= '0;
            lvl_q     <= '0;
            res_count <= '0;
            res_pass  <= 1'b0;
            res_sat   <= 1'b0;
        end else begin
            if (clear) begin
                acc   <= '0;
                sat   <= 1'b0;
                log_q <= log_c;
                lvl_q <= lvl;
            end else if (add) begin
                acc <= acc + ACC_W'(sample);
                // a count equal to the window means the comparator never tripped
                sat <= sat | (ACC_W'(sample) == ACC_W'(win));
            end
            if (result) begin
                res_count <= avg;
                res_pass  <= (avg < lvl_q);
                res_sat   <= sat;
            end
        end
    end

endmodule

// File: rtl/dsm_read_ctrl.sv
// Read/verify sequencer for the bit-line delta-sigma modulator: settles,
// opens a counting window, captures and averages, returns pass/fail.
module dsm_read_ctrl #(
    parameter int CNT_W       = dsm_pkg::CNT_W,
    parameter int WIN_W       = dsm_pkg::WIN_W,
    parameter int AVG_LOG_MAX = dsm_pkg::AVG_LOG_MAX,
    parameter int SETTLE_CYC  = dsm_pkg::SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic [1:0]       avg_log,
    input  logic [CNT_W-1:0] verify_lvl,
    input  logic [CNT_W-1:0] dsm_cnt,
    output logic             dsm_en,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_pass,
    output logic             res_sat
);
    import dsm_pkg::*;

    localparam int CW = AVG_LOG_MAX + 1;

    rd_state_e        state, state_d;
    logic [WIN_W-1:0] tmr, win_q;
    logic [CW-1:0]    conv, conv_nxt, n_conv;
    logic [CNT_W-1:0] cap;
    logic [1:0]       n_log;
    logic             clr, add, load;

    assign conv_nxt = conv + CW'(1);
    assign n_conv   = CW'(1) << n_log;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        clr     = 1'b0;
        add     = 1'b0;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !res_valid) begin
                    state_d = SETTLE;
                    clr     = 1'b1;
                end
            end
            SETTLE: if (tmr == WIN_W'(SETTLE_CYC - 1)) state_d = CONV;
            CONV:   if (tmr == win_q - WIN_W'(1)) state_d = CAPT;
            CAPT:   state_d = ACC;
            ACC: begin
                add     = 1'b1;
                state_d = (conv_nxt < n_conv) ? SETTLE : DONE;
            end
            DONE: begin
                if (!res_valid)     load    = 1'b1;
                else if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr       <= '0;
            win_q     <= WIN_W'(1);
            conv      <= '0;
            res_valid <= 1'b0;
        end else begin
            tmr <= (state_d != state) ? '0 : tmr + WIN_W'(1);
            if (clr) begin
                win_q <= (win_len == '0) ? WIN_W'(1) : win_len;
                conv  <= '0;
            end else if (add) begin
                conv <= conv_nxt;
            end
            if (load)                        res_valid <= 1'b1;
            else if (res_valid && res_ready) res_valid <= 1'b0;
        end
    end

    // falling-edge flops give the DSM half a cycle of setup and read a stable count
    always_ff @(negedge clk) begin
        dsm_en <= rst_n && (state == CONV);
        if (state == CAPT) cap <= dsm_cnt;
    end

    dsm_avg_acc #(
        .CNT_W       (CNT_W),
        .WIN_W       (WIN_W),
        .AVG_LOG_MAX (AVG_LOG_MAX)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clr),
        .avg_log   (avg_log),
        .lvl       (verify_lvl),
        .add       (add),
        .sample    (cap),
        .win       (win_q),
        .result    (load),
        .n_log     (n_log),
        .res_count (res_count),
        .res_pass  (res_pass),
        .res_sat   (res_sat)
    );

endmodule

// File: tb/tb_dsm_read_ctrl.sv
// Directed bench for dsm_read_ctrl with a behavioural DSM and a
// reference model of the averaged read result.
module tb_dsm_read_ctrl;
    import dsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] win_len = '0;
    logic [1:0] avg_log = '0;
    logic [8:0] verify_lvl = '0;
    logic [8:0] dsm_cnt = '0;
    logic       dsm_en;
    logic       busy;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [8:0] res_count;
    logic       res_pass;
    logic       res_sat;

    dsm_read_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .win_len    (win_len),
        .avg_log    (avg_log),
        .verify_lvl (verify_lvl),
        .dsm_cnt    (dsm_cnt),
        .dsm_en     (dsm_en),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_count  (res_count),
        .res_pass   (res_pass),
        .res_sat    (res_sat)
    );

    always #5 clk = ~clk;

    int tot = 0;
    int npass = 0;
    int tgt[4];
    int base = 0;
    int conv_i = 0;
    int en_run = 0;
    int wlen[256];
    int exp_cnt, exp_pass, exp_sat;
    bit chk_en = 1'b0;

    // DSM: counts up to the per-conversion target while enabled, clears when off
    always @(posedge clk) begin
        if (dsm_en !== 1'b1) begin
            if (en_run > 0) begin
                wlen[conv_i % 256] = en_run;
                conv_i++;
            end
            en_run = 0;
            dsm_cnt <= '0;
        end else begin
            en_run++;
            if (int'(dsm_cnt) < tgt[(conv_i - base) & 3])
                dsm_cnt <= dsm_cnt + 9'd1;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        tot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        logic r, v;
        r = res_ready;
        v = res_valid;
        @(posedge clk);
        #1;
        if (chk_en && res_valid) begin
            check("res_count", int'(res_count), exp_cnt);
            check("res_pass", int'(res_pass), exp_pass);
            check("res_sat", int'(res_sat), exp_sat);
        end
        if (chk_en && v && !r) check("valid_hold", int'(res_valid), 1);
    endtask

    task automatic run(input int win, input int alog, input int lvl,
                       input int t0, input int t1, input int t2, input int t3,
                       input int l_cnt, input int l_pass, input int l_sat,
                       input int l_lat, input bit early, input bit hold);
        int n, w, sum, avg, mp, ms, lat, e, c;
        int tv[4];
        tv[0] = t0; tv[1] = t1; tv[2] = t2; tv[3] = t3;
        n = 1 << alog;
        w = (win == 0) ? 1 : win;
        sum = 0;
        ms = 0;
        for (int i = 0; i < n; i++) begin
            c = (tv[i] < w) ? tv[i] : w;
            sum += c;
            if (c == w) ms = 1;
        end
        avg = sum >> alog;
        mp = (avg < lvl) ? 1 : 0;
        lat = n * (w + SETTLE_CYC + 2) + 1;
        check("model_count", avg, l_cnt);
        check("model_pass", mp, l_pass);
        check("model_sat", ms, l_sat);
        check("model_latency", lat, l_lat);

        for (int i = 0; i < 4; i++) tgt[i] = tv[i];
        base = conv_i;
        exp_cnt = avg;
        exp_pass = mp;
        exp_sat = ms;
        chk_en = 1'b1;
        res_ready = early;

        @(negedge clk);
        win_len = 9'(win);
        avg_log = 2'(alog);
        verify_lvl = 9'(lvl);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        e = 0;
        while (!res_valid && e < lat + 20) begin
            tick();
            e++;
        end
        check("latency", e, lat);

        if (early) begin
            tick();
            res_ready = 1'b0;
        end else begin
            if (hold) begin
                for (int i = 0; i < 20; i++) begin
                    if (i == 5) start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                check("valid_after_hold", int'(res_valid), 1);
            end
            start = 1'b1;
            res_ready = 1'b1;
            tick();
            start = 1'b0;
            res_ready = 1'b0;
        end
        check("valid_clear", int'(res_valid), 0);
        check("idle_after_ack", int'(busy), 0);
        repeat (3) tick();
        check("start_dropped", int'(busy), 0);
        check("count_held", int'(res_count), avg);
        for (int k = 0; k < n; k++)
            check("window_edges", wlen[(base + k) % 256], w);
        chk_en = 1'b0;
    endtask

    initial begin
        bit seen;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_count", int'(res_count), 0);
        check("rst_pass", int'(res_pass), 0);
        check("rst_sat", int'(res_sat), 0);
        check("rst_dsm_en", int'(dsm_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run(100, 0, 50, 511, 511, 511, 511, 100, 0, 1, 105, 1'b0, 1'b1);
        run(200, 2, 40, 37, 37, 37, 37, 37, 1, 0, 817, 1'b0, 1'b0);
        run(30, 2, 11, 10, 11, 11, 11, 10, 1, 0, 137, 1'b1, 1'b0);
        run(20, 0, 5, 0, 0, 0, 0, 0, 1, 0, 25, 1'b0, 1'b0);
        run(20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 25, 1'b0, 1'b0);
        run(0, 1, 1, 511, 511, 511, 511, 1, 0, 1, 11, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) tgt[i] = 511;
        base = conv_i;
        @(negedge clk);
        win_len = 9'd50;
        avg_log = 2'd0;
        verify_lvl = 9'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("mid_conv_dsm_en", int'(dsm_en), 1);
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(res_valid), 0);
        check("abort_count", int'(res_count), 0);
        check("abort_pass", int'(res_pass), 0);
        check("abort_sat", int'(res_sat), 0);
        @(negedge clk);
        #1;
        check("abort_dsm_en", int'(dsm_en), 0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check("abort_no_valid", int'(seen), 0);
        check("abort_stays_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", npass, tot);
        $finish;
    end

endmodule
